// File: rtl/issue_sched_sb_if.sv
// Decode-group and issue-result bundle for the N-wide issue scheduler.
// The decoder is master; the scheduler is slave.
interface issue_sched_sb_if #(
    parameter int NUM_SLOTS = 2
);
    localparam int ICW = $clog2(NUM_SLOTS + 1);

    logic                   flush;
    logic [NUM_SLOTS-1:0]   slot_valid;
    logic [5*NUM_SLOTS-1:0] rs1;
    logic [5*NUM_SLOTS-1:0] rs2;
    logic [5*NUM_SLOTS-1:0] rd;
    logic [NUM_SLOTS-1:0]   use_rs1;
    logic [NUM_SLOTS-1:0]   use_rs2;
    logic [NUM_SLOTS-1:0]   reg_write;
    logic [NUM_SLOTS-1:0]   mem_read;
    logic [NUM_SLOTS-1:0]   mem_write;
    logic [NUM_SLOTS-1:0]   branch;
    logic [NUM_SLOTS-1:0]   jump;
    logic [NUM_SLOTS-1:0]   is_lui;
    logic [NUM_SLOTS-1:0]   is_auipc;
    logic [NUM_SLOTS-1:0]   system;
    logic [NUM_SLOTS-1:0]   issue_vec;
    logic [ICW-1:0]         issue_cnt;
    logic                   stall_if;
    logic                   halted;
    logic [31:0]            busy_vec;
    logic [31:0]            load_pending_vec;

    modport master (
        output flush, slot_valid, rs1, rs2, rd,
        output use_rs1, use_rs2, reg_write,
        output mem_read, mem_write, branch, jump,
        output is_lui, is_auipc, system,
        input  issue_vec, issue_cnt, stall_if,
        input  halted, busy_vec, load_pending_vec
    );

    modport slave (
        input  flush, slot_valid, rs1, rs2, rd,
        input  use_rs1, use_rs2, reg_write,
        input  mem_read, mem_write, branch, jump,
        input  is_lui, is_auipc, system,
        output issue_vec, issue_cnt, stall_if,
        output halted, busy_vec, load_pending_vec
    );
endinterface

// File: rtl/issue_sched_sb.sv
// N-wide in-order issue scheduler with per-register latency scoreboard.
// Issues the longest hazard-free prefix; halts for good after a SYSTEM.
module issue_sched_sb #(
    parameter int NUM_SLOTS = 2,
    parameter int ALU_LAT   = 1,
    parameter int LOAD_LAT  = 2,
    parameter int CW        = $clog2(LOAD_LAT + 1)
) (
    input logic             clk,
    input logic             rst,
    issue_sched_sb_if.slave sb
);
    localparam int ICW = $clog2(NUM_SLOTS + 1);

    typedef enum logic {RUN, HALT} state_t;

    state_t state;
    state_t state_nx;
    logic   run;
    logic   halted;

    logic [CW-1:0] cnt [32];
    logic [31:0]   lp;
    logic [31:0]   busy;
    logic [31:0]   set_r;
    logic [31:0]   set_ld;

    logic [4:0] a1  [NUM_SLOTS];
    logic [4:0] a2  [NUM_SLOTS];
    logic [4:0] dst [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] v1;
    logic [NUM_SLOTS-1:0] v2;
    logic [NUM_SLOTS-1:0] wr;
    logic [NUM_SLOTS-1:0] ld;
    logic [NUM_SLOTS-1:0] mem;
    logic [NUM_SLOTS-1:0] bj;
    logic [NUM_SLOTS-1:0] iss;
    logic [ICW-1:0]       pop;

    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            a1[k]  = sb.rs1[5*k +: 5];
            a2[k]  = sb.rs2[5*k +: 5];
            dst[k] = sb.rd[5*k +: 5];
            v1[k]  = sb.use_rs1[k] && (a1[k] != 5'd0);
            v2[k]  = sb.use_rs2[k] && (a2[k] != 5'd0);
            wr[k]  = sb.reg_write[k] && (dst[k] != 5'd0);
            ld[k]  = sb.mem_read[k] && wr[k];
            mem[k] = sb.mem_read[k] || sb.mem_write[k];
            bj[k]  = sb.branch[k] || sb.jump[k];
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++)
            busy[r] = (cnt[r] != '0);
    end

    // ok carries "every older slot issued and none was a SYSTEM"
    always_comb begin
        logic ok;
        logic haz;
        iss = '0;
        ok  = run;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (k == 0) begin
                haz = (v1[k] && busy[a1[k]] && lp[a1[k]])
                   || (v2[k] && busy[a2[k]] && lp[a2[k]])
                   || (wr[k] && lp[dst[k]]);
            end else begin
                haz = (v1[k] && busy[a1[k]])
                   || (v2[k] && busy[a2[k]])
                   || (wr[k] && busy[dst[k]])
                   || sb.jump[k] || sb.is_lui[k]
                   || sb.is_auipc[k];
                for (int j = 0; j < k; j++) begin
                    if (wr[j] && v1[k] && a1[k] == dst[j])
                        haz = 1'b1;
                    if (wr[j] && v2[k] && a2[k] == dst[j])
                        haz = 1'b1;
                    if (wr[k] && wr[j] && dst[k] == dst[j])
                        haz = 1'b1;
                    if (wr[k] && v1[j] && a1[j] == dst[k])
                        haz = 1'b1;
                    if (wr[k] && v2[j] && a2[j] == dst[k])
                        haz = 1'b1;
                    if (mem[k] && mem[j])
                        haz = 1'b1;
                    if (bj[k] && bj[j])
                        haz = 1'b1;
                end
            end
            iss[k] = ok && sb.slot_valid[k]
                  && (sb.system[k] || !haz);
            ok = iss[k] && !sb.system[k];
        end
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < NUM_SLOTS; k++)
            pop = pop + ICW'(iss[k]);
    end

    // WAW is blocked in-group, so at most one issuing writer per rd
    always_comb begin
        set_r  = '0;
        set_ld = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (iss[k] && wr[k]) begin
                set_r[dst[k]]  = 1'b1;
                set_ld[dst[k]] = ld[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || sb.flush) begin
            for (int r = 0; r < 32; r++)
                cnt[r] <= '0;
            lp <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (set_r[r]) begin
                    cnt[r] <= set_ld[r] ? CW'(LOAD_LAT)
                                        : CW'(ALU_LAT);
                    lp[r]  <= set_ld[r];
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                    if (cnt[r] == CW'(1))
                        lp[r] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == RUN && !sb.flush && |(iss & sb.system))
            state_nx = HALT;
    end

    always_comb begin
        run    = (state == RUN);
        halted = (state == HALT);
    end

    assign sb.issue_vec        = iss;
    assign sb.issue_cnt        = pop;
    assign sb.stall_if         = sb.slot_valid[0] && !iss[0] && run;
    assign sb.halted           = halted;
    assign sb.busy_vec         = busy;
    assign sb.load_pending_vec = {lp[31:1], 1'b0};
endmodule

// File: tb/tb_issue_sched_sb.sv
// Directed bench for issue_sched_sb: a 4-wide vector table plus
// hand-written multi-cycle sequences on a 2-wide instance.
module tb_issue_sched_sb;
    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       br;
        logic       jp;
        logic       lu;
        logic       au;
        logic       sy;
    } instr_t;

    typedef struct packed {
        instr_t [3:0] s;
        logic [3:0]   iv;
        logic [2:0]   ic;
        logic         st;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    issue_sched_sb_if #(.NUM_SLOTS(2)) b2();
    issue_sched_sb_if #(.NUM_SLOTS(4)) b4();

    issue_sched_sb #(.NUM_SLOTS(2)) u2 (
        .clk(clk), .rst(rst), .sb(b2)
    );
    issue_sched_sb #(.NUM_SLOTS(4)) u4 (
        .clk(clk), .rst(rst), .sb(b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    function automatic instr_t none();
        instr_t i;
        i = '0;
        return i;
    endfunction

    function automatic instr_t alu(int d, int a, int b);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rd = 5'(d); i.rs1 = 5'(a); i.rs2 = 5'(b);
        i.u1 = 1'b1; i.u2 = 1'b1; i.rw = 1'b1;
        return i;
    endfunction

    function automatic instr_t lw(int d, int a);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rd = 5'(d); i.rs1 = 5'(a);
        i.u1 = 1'b1; i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic instr_t sw(int a, int b);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rs1 = 5'(a); i.rs2 = 5'(b);
        i.u1 = 1'b1; i.u2 = 1'b1; i.mw = 1'b1;
        return i;
    endfunction

    function automatic instr_t br(int a, int b);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rs1 = 5'(a); i.rs2 = 5'(b);
        i.u1 = 1'b1; i.u2 = 1'b1; i.br = 1'b1;
        return i;
    endfunction

    function automatic instr_t lui(int d);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rd = 5'(d); i.rw = 1'b1; i.lu = 1'b1;
        return i;
    endfunction

    function automatic instr_t ecall();
        instr_t i;
        i = '0;
        i.v = 1'b1; i.sy = 1'b1;
        return i;
    endfunction

    function automatic vec_t mk(instr_t a, instr_t b, instr_t c,
                                instr_t d, logic [3:0] iv,
                                logic [2:0] ic, logic st);
        vec_t r;
        r.s[0] = a; r.s[1] = b; r.s[2] = c; r.s[3] = d;
        r.iv = iv; r.ic = ic; r.st = st;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h",
                     nm, act, exp);
        end
    endtask

    task automatic put2(int k, instr_t i);
        b2.slot_valid[k]   = i.v;
        b2.rs1[5*k +: 5]   = i.rs1;
        b2.rs2[5*k +: 5]   = i.rs2;
        b2.rd[5*k +: 5]    = i.rd;
        b2.use_rs1[k]      = i.u1;
        b2.use_rs2[k]      = i.u2;
        b2.reg_write[k]    = i.rw;
        b2.mem_read[k]     = i.mr;
        b2.mem_write[k]    = i.mw;
        b2.branch[k]       = i.br;
        b2.jump[k]         = i.jp;
        b2.is_lui[k]       = i.lu;
        b2.is_auipc[k]     = i.au;
        b2.system[k]       = i.sy;
    endtask

    task automatic put4(int k, instr_t i);
        b4.slot_valid[k]   = i.v;
        b4.rs1[5*k +: 5]   = i.rs1;
        b4.rs2[5*k +: 5]   = i.rs2;
        b4.rd[5*k +: 5]    = i.rd;
        b4.use_rs1[k]      = i.u1;
        b4.use_rs2[k]      = i.u2;
        b4.reg_write[k]    = i.rw;
        b4.mem_read[k]     = i.mr;
        b4.mem_write[k]    = i.mw;
        b4.branch[k]       = i.br;
        b4.jump[k]         = i.jp;
        b4.is_lui[k]       = i.lu;
        b4.is_auipc[k]     = i.au;
        b4.system[k]       = i.sy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        b2.flush = 1'b0;
        b4.flush = 1'b0;
        for (int k = 0; k < 2; k++) put2(k, none());
        for (int k = 0; k < 4; k++) put4(k, none());
        tick();
        rst = 1'b0;
    endtask

    vec_t vt[13];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;

        vt[0]  = mk(alu(1,20,21), alu(2,22,23), alu(3,24,25),
                    alu(4,26,27), 4'b1111, 3'd4, 1'b0);
        vt[1]  = mk(sw(1,2), alu(10,11,12), lw(13,14),
                    alu(15,16,17), 4'b0011, 3'd2, 1'b0);
        vt[2]  = mk(none(), alu(10,11,12), alu(13,14,15),
                    alu(16,17,18), 4'b0000, 3'd0, 1'b0);
        vt[3]  = mk(none(), none(), none(), none(),
                    4'b0000, 3'd0, 1'b0);
        vt[4]  = mk(alu(3,4,5), alu(6,3,1), alu(7,8,9),
                    alu(10,11,12), 4'b0001, 3'd1, 1'b0);
        vt[5]  = mk(alu(3,4,5), alu(3,6,7), alu(8,9,10),
                    alu(11,12,13), 4'b0001, 3'd1, 1'b0);
        vt[6]  = mk(alu(3,4,5), alu(4,6,7), alu(8,9,10),
                    alu(11,12,13), 4'b0001, 3'd1, 1'b0);
        vt[7]  = mk(br(1,2), alu(10,11,12), br(3,4),
                    alu(13,14,15), 4'b0011, 3'd2, 1'b0);
        vt[8]  = mk(alu(10,11,12), lui(13), alu(14,15,16),
                    alu(17,18,19), 4'b0001, 3'd1, 1'b0);
        vt[9]  = mk(alu(3,4,5), ecall(), alu(6,7,8),
                    alu(9,10,11), 4'b0011, 3'd2, 1'b0);
        vt[10] = mk(ecall(), alu(6,7,8), alu(9,10,11),
                    alu(12,13,14), 4'b0001, 3'd1, 1'b0);
        vt[11] = mk(lw(5,1), alu(6,5,1), alu(7,8,9),
                    alu(10,11,12), 4'b0001, 3'd1, 1'b0);
        vt[12] = mk(alu(1,20,21), alu(2,22,23), alu(3,24,25),
                    alu(4,1,26), 4'b0111, 3'd3, 1'b0);

        // reset state on both widths
        reset_all();
        #2;
        chk("rst2_issue", 32'(b2.issue_vec), 32'h0);
        chk("rst2_halted", 32'(b2.halted), 32'h0);
        chk("rst2_busy", b2.busy_vec, 32'h0);
        chk("rst2_lp", b2.load_pending_vec, 32'h0);
        chk("rst4_issue", 32'(b4.issue_vec), 32'h0);
        chk("rst4_halted", 32'(b4.halted), 32'h0);
        chk("rst4_busy", b4.busy_vec, 32'h0);
        chk("rst4_lp", b4.load_pending_vec, 32'h0);

        // single-cycle issue decisions from a clean scoreboard
        for (int i = 0; i < 13; i++) begin
            reset_all();
            for (int k = 0; k < 4; k++) put4(k, vt[i].s[k]);
            #2;
            chk($sformatf("vec%0d_issue", i),
                32'(b4.issue_vec), 32'(vt[i].iv));
            chk($sformatf("vec%0d_cnt", i),
                32'(b4.issue_cnt), 32'(vt[i].ic));
            chk($sformatf("vec%0d_stall", i),
                32'(b4.stall_if), 32'(vt[i].st));
        end

        // four ALU writers: busy for exactly ALU_LAT cycle
        reset_all();
        for (int k = 0; k < 4; k++) put4(k, vt[0].s[k]);
        tick();
        for (int k = 0; k < 4; k++) put4(k, none());
        #2;
        chk("alu4_busy", b4.busy_vec, 32'h1e);
        tick();
        #2;
        chk("alu4_drain", b4.busy_vec, 32'h0);

        // load-use: lw x5 then add x7,x5 stalls two cycles
        reset_all();
        put2(0, lw(5,1));
        put2(1, alu(6,5,1));
        #2;
        chk("lu_issue0", 32'(b2.issue_vec), 32'h1);
        tick();
        put2(0, alu(7,5,0));
        put2(1, none());
        #2;
        chk("lu_busy", b2.busy_vec, 32'h20);
        chk("lu_lp", b2.load_pending_vec, 32'h20);
        chk("lu_stall1", 32'(b2.stall_if), 32'h1);
        chk("lu_issue1", 32'(b2.issue_vec), 32'h0);
        tick();
        #2;
        chk("lu_stall2", 32'(b2.stall_if), 32'h1);
        tick();
        #2;
        chk("lu_stall3", 32'(b2.stall_if), 32'h0);
        chk("lu_issue3", 32'(b2.issue_vec), 32'h1);
        tick();
        put2(0, none());
        #2;
        chk("lu_busy_after", b2.busy_vec, 32'h80);

        // WAR in group, then SYSTEM halt behaviour
        reset_all();
        put2(0, alu(3,4,5));
        put2(1, alu(4,6,7));
        #2;
        chk("war_issue", 32'(b2.issue_vec), 32'h1);
        reset_all();
        put2(0, alu(3,4,5));
        put2(1, ecall());
        #2;
        chk("sys_issue", 32'(b2.issue_vec), 32'h3);
        chk("sys_halt_pre", 32'(b2.halted), 32'h0);
        tick();
        #2;
        chk("sys_halted", 32'(b2.halted), 32'h1);
        chk("sys_issue_halt", 32'(b2.issue_vec), 32'h0);
        chk("sys_stall_halt", 32'(b2.stall_if), 32'h0);
        chk("sys_busy", b2.busy_vec, 32'h8);
        tick();
        #2;
        chk("sys_drain", b2.busy_vec, 32'h0);
        b2.flush = 1'b1;
        tick();
        b2.flush = 1'b0;
        #2;
        chk("sys_flush_sticky", 32'(b2.halted), 32'h1);
        reset_all();
        #2;
        chk("sys_rst_clear", 32'(b2.halted), 32'h0);

        // flush clears a pending load and drops same-cycle issue
        reset_all();
        put2(0, lw(9,1));
        tick();
        b2.flush = 1'b1;
        put2(0, alu(10,1,2));
        tick();
        b2.flush = 1'b0;
        put2(0, none());
        #2;
        chk("flush_busy", b2.busy_vec, 32'h0);
        chk("flush_lp", b2.load_pending_vec, 32'h0);

        // WAW against a pending load waits for lp to clear
        reset_all();
        put2(0, lw(8,1));
        tick();
        put2(0, alu(8,1,2));
        #2;
        chk("waw_stall1", 32'(b2.stall_if), 32'h1);
        chk("waw_lp", b2.load_pending_vec, 32'h100);
        tick();
        #2;
        chk("waw_stall2", 32'(b2.stall_if), 32'h1);
        tick();
        #2;
        chk("waw_stall3", 32'(b2.stall_if), 32'h0);
        chk("waw_issue", 32'(b2.issue_vec), 32'h1);
        tick();
        put2(0, none());
        #2;
        chk("waw_busy", b2.busy_vec, 32'h100);
        chk("waw_lp_clear", b2.load_pending_vec, 32'h0);
        tick();
        #2;
        chk("waw_alu_lat", b2.busy_vec, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule

// File: doc/issue_sched_sb.md
Name: issue_sched_sb

Overview:
- Parametrised N-wide in-order issue scheduler with an integrated register scoreboard. It is the successor to the combinational dual-issue checker.
- Sits between decode (ID0..ID{N-1}) and execute.
- Each cycle it issues the longest hazard-free in-order prefix of the decode group.
- It tracks in-flight producers with per-register latency countdowns and halts issue permanently once a SYSTEM instruction issues.

Parameters:
- NUM_SLOTS, 2, decode/issue width (2..4); slot 0 is oldest.
- ALU_LAT, 1, cycles a non-load writer keeps its rd busy (>=1).
- LOAD_LAT, 2, cycles a load keeps its rd busy (>=ALU_LAT).
- CW, $clog2(LOAD_LAT+1), countdown width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; clears scoreboard
- slot_valid  in  NUM_SLOTS  slot k holds a real instruction
- rs1, rs2, rd  in  5*NUM_SLOTS  register indices, slot k at [5k+4:5k]
- use_rs1, use_rs2  in  NUM_SLOTS  source actually read
- reg_write, mem_read, mem_write, branch, jump, is_lui, is_auipc, system  in  NUM_SLOTS each  decoded control bits
- issue_vec  out  NUM_SLOTS  slots issuing this cycle (always a prefix mask)
- issue_cnt  out  $clog2(NUM_SLOTS+1)  popcount of issue_vec
- stall_if  out  1  hold fetch/decode
- halted  out  1  SYSTEM has issued
- busy_vec  out  32  cnt[r]!=0
- load_pending_vec  out  32  lp[r]

Behaviour:
- Reset: cnt[*]=0, lp[*]=0, FSM=RUN. Outputs after reset: issue_vec=0 until slot_valid is presented, halted=0, busy_vec=0, load_pending_vec=0.
- Definitions:
  - src valid = use && idx!=0.
  - writer = reg_write && rd!=0.
  - load = mem_read && writer.
- Slot 0 blocked (RUN state) if any of:
  - !slot_valid[0].
  - A valid source with busy && lp (load-use).
  - writer && lp[rd0] (WAW with pending load).
  - ALU-latency sources never block slot 0; forwarding covers them.
- Slot k>0 blocked if any of:
  - Any older slot is not issued.
  - !slot_valid[k].
  - Any valid source busy (any producer).
  - writer && busy[rd].
  - RAW/WAW/WAR against any older slot j<k in the group.
  - RAW with an older load in the group.
  - Memory op while an older issued slot is a memory op (one mem op per cycle).
  - Branch/jump while an older issued slot is branch/jump.
  - jump, is_lui or is_auipc (slot 0 only).
- SYSTEM:
  - A SYSTEM in slot k issues whenever all older slots issue, regardless of data hazards.
  - No slot younger than a SYSTEM issues in that cycle.
- issue_vec is combinational from current state and inputs; it is 0 whenever FSM=HALT.
- stall_if = slot_valid[0] && !issue_vec[0] && FSM==RUN.
- Scoreboard update, at posedge, in priority order:
  1. rst.
  2. flush: all cnt=0, lp=0. Issue in the same cycle is discarded; FSM unchanged.
  3. Issuing writer in slot k: cnt[rd]=LOAD_LAT or ALU_LAT, lp[rd]=load. The youngest issuing writer wins, but WAW is excluded so there is no collision.
  4. Otherwise, if cnt!=0: cnt--, and lp cleared when cnt becomes 0.
  - An issue to a register overrides its decrement in the same cycle.
- FSM:
  - RUN -> HALT when any issued slot has system=1. halted=1 from the next cycle.
  - HALT is sticky; only rst exits it, flush does not.
  - In HALT, stall_if=0 and counters keep draining.
- busy_vec[0] and load_pending_vec[0] are always 0.

Test Plan:
- NUM_SLOTS=2, slot0 `lw x5`, slot1 `add x6,x5,x1` -> issue_vec=01. Next cycle busy[5]=1, lp[5]=1, cnt=2. A following `add x7,x5` in slot0 stalls 2 cycles (stall_if=1), then issues.
- NUM_SLOTS=4, four independent ALU ops x1..x4 -> issue_vec=1111, issue_cnt=4. Next cycle busy_vec=0x1E; 1 cycle later busy_vec=0.
- NUM_SLOTS=4: slot0 `sw`, slot1 `add`, slot2 `lw`, slot3 `add` -> issue_vec=0011. slot2 is blocked by the mem conflict and slot3 is blocked by prefix order.
- NUM_SLOTS=2: slot0 `add x3,x4,x5`, slot1 `add x4,x6,x7` (WAR) -> issue_vec=01. slot1 with `ecall` in place of that add -> issue_vec=11, halted=1 next cycle, issue_vec=0 afterwards despite valid slots. flush has no effect; rst clears halted.
- Issue `lw x9`, then assert flush the next cycle together with an ALU writer to x10 -> busy_vec=0 and load_pending_vec=0 after the edge. The x10 issue is discarded.
- Issue `lw x8` (cnt[8]=2). One cycle later slot0 `add x8,x1,x2` (WAW with pending load) -> stalled until lp[8] clears, then cnt[8]=ALU_LAT, lp[8]=0.
